hyperbus_pad_frame: RTL and testbench

Parametrised pad frame for the HyperBus controller. It connects NumPhys controller PHY channels to bidirectional pad cells. It adds a register-programmable pad configuration per PHY, a reset-release sequencer for hyper_reset_no, and a direction-turnaround contention monitor. It sits between the hyperbus controller and the chip pad ring and replaces fixed, hard-tied pad instantiation.

---
 rtl/hyperbus_pad_pkg.sv | 22 ++
 rtl/hyperbus_pad_cell.sv | 19 +
 rtl/hyperbus_pad_frame.sv | 183 ++++++++++++++++++
 tb/tb_hyperbus_pad_frame.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pad_pkg.sv
// Shared register offsets, ID and pad configuration type for the HyperBus pad frame.
package hyperbus_pad_pkg;

    localparam logic [31:0] HyperId = 32'h4842_5031;

    localparam logic [7:0] RegId     = 8'h00;
    localparam logic [7:0] RegCtrl   = 8'h04;
    localparam logic [7:0] RegStatus = 8'h08;
    localparam logic [7:0] RegPadcfg = 8'h10;
    localparam logic [7:0] RegErrcnt = 8'h30;

    typedef struct packed {
        logic [1:0] drv;
        logic       sr;
        logic       smt;
        logic       pd;
        logic       pu;
    } pad_cfg_t;

    localparam pad_cfg_t PadCfgRst = '0;

endpackage

// File: rtl/hyperbus_pad_cell.sv
// Behavioural stand-in for the technology bidirectional pad cell.
// The cfg pins feed pull, Schmitt, slew and drive controls of the real cell.
module hyperbus_pad_cell
    import hyperbus_pad_pkg::*;
(
    input  logic     dout,
    output logic     din,
    input  logic     oe,
    inout  wire      pad,
    input  pad_cfg_t cfg
);

    logic cfg_unused;

    assign pad        = oe ? dout : 1'bz;
    assign din        = pad;
    assign cfg_unused = ^cfg;

endmodule

// File: rtl/hyperbus_pad_frame.sv
// HyperBus pad frame: pad config registers, RESET# sequencer and turnaround monitor.
// Optional build macro HYPER_PAD_LOOPBACK_EN adds CTRL.LOOPBACK (DQ/RWDS internal loop).
module hyperbus_pad_frame
    import hyperbus_pad_pkg::*;
#(
    parameter int unsigned NumPhys       = 2,
    parameter int unsigned NumChips      = 2,
    parameter int unsigned DqWidth       = 8,
    parameter int unsigned TurnCycles    = 2,
    parameter int unsigned RstHoldCycles = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          reg_req_i,
    input  logic                          reg_we_i,
    input  logic [7:0]                    reg_addr_i,
    input  logic [31:0]                   reg_wdata_i,
    output logic [31:0]                   reg_rdata_o,
    output logic                          reg_ready_o,
    input  logic [NumPhys-1:0]            ctl_ck_i,
    input  logic [NumPhys-1:0]            ctl_ck_n_i,
    input  logic [NumPhys*NumChips-1:0]   ctl_cs_n_i,
    input  logic [NumPhys*DqWidth-1:0]    ctl_dq_o_i,
    input  logic [NumPhys-1:0]            ctl_dq_oe_i,
    output logic [NumPhys*DqWidth-1:0]    ctl_dq_i_o,
    input  logic [NumPhys-1:0]            ctl_rwds_o_i,
    input  logic [NumPhys-1:0]            ctl_rwds_oe_i,
    output logic [NumPhys-1:0]            ctl_rwds_i_o,
    output logic [NumPhys-1:0]            hyper_ck_o,
    output logic [NumPhys-1:0]            hyper_ck_no,
    output logic [NumPhys*NumChips-1:0]   hyper_cs_no,
    output logic [NumPhys-1:0]            hyper_reset_no,
    inout  wire  [NumPhys*DqWidth-1:0]    hyper_dq_io,
    inout  wire  [NumPhys-1:0]            hyper_rwds_io
);

    logic                     accept;
    logic                     wr;
    logic                     wr_ctrl;
    logic                     wr_status;
    logic [NumPhys-1:0]       wr_cfg;
    logic [NumPhys-1:0]       wr_err;
    logic [31:0]              rdata;
    logic                     lb;
    logic                     wdata_unused;

    pad_cfg_t                 padcfg [NumPhys];
    logic [7:0]               errcnt [NumPhys];
    logic [3:0]               turn_cnt [NumPhys];
    logic [NumPhys-1:0]       status;
    logic [NumPhys-1:0]       status_clr;
    logic [NumPhys-1:0]       oe_q;
    logic [NumPhys-1:0]       fall;
    logic [NumPhys-1:0]       viol;
    logic [7:0]               rst_cnt;

    logic [NumPhys-1:0]       dq_oe;
    logic [NumPhys-1:0]       rwds_oe;
    logic [NumPhys*DqWidth-1:0] dq_di;
    logic [NumPhys-1:0]       rwds_di;

    assign accept       = reg_req_i && !reg_ready_o;
    assign wr           = accept && reg_we_i;
    assign wdata_unused = ^reg_wdata_i[31:6];
    assign status_clr   = wr_status ? reg_wdata_i[NumPhys-1:0] : '0;

    always_comb begin
        rdata     = '0;
        wr_ctrl   = wr && (reg_addr_i == RegCtrl);
        wr_status = wr && (reg_addr_i == RegStatus);
        wr_cfg    = '0;
        wr_err    = '0;
        if (reg_addr_i == RegId)     rdata = HyperId;
        if (reg_addr_i == RegCtrl)   rdata = {30'd0, lb, 1'b0};
        if (reg_addr_i == RegStatus) rdata = 32'(status);
        for (int p = 0; p < NumPhys; p++) begin
            if (reg_addr_i == RegPadcfg + 8'(4 * p)) begin
                rdata     = 32'(padcfg[p]);
                wr_cfg[p] = wr;
            end
            if (reg_addr_i == RegErrcnt + 8'(4 * p)) begin
                rdata     = 32'(errcnt[p]);
                wr_err[p] = wr;
            end
        end
    end

    // The falling cycle itself is the first idle cycle of the turnaround.
    always_comb begin
        fall = '0;
        viol = '0;
        for (int p = 0; p < NumPhys; p++) begin
            fall[p] = oe_q[p] && !ctl_dq_oe_i[p];
            viol[p] = !oe_q[p] && ctl_dq_oe_i[p] && (turn_cnt[p] != 4'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_ready_o <= 1'b0;
            reg_rdata_o <= '0;
            status      <= '0;
            oe_q        <= '0;
            rst_cnt     <= 8'(RstHoldCycles);
            for (int p = 0; p < NumPhys; p++) begin
                padcfg[p]   <= PadCfgRst;
                errcnt[p]   <= '0;
                turn_cnt[p] <= '0;
            end
        end else begin
            reg_ready_o <= accept;
            reg_rdata_o <= (accept && !reg_we_i) ? rdata : '0;
            status      <= (status & ~status_clr) | viol;
            oe_q        <= ctl_dq_oe_i;
            if (wr_ctrl && reg_wdata_i[0]) begin
                rst_cnt <= 8'(RstHoldCycles);
            end else if (rst_cnt != 8'd0) begin
                rst_cnt <= rst_cnt - 8'd1;
            end
            for (int p = 0; p < NumPhys; p++) begin
                if (wr_cfg[p]) padcfg[p] <= pad_cfg_t'(reg_wdata_i[5:0]);
                if (fall[p]) begin
                    turn_cnt[p] <= 4'(TurnCycles - 1);
                end else if (turn_cnt[p] != 4'd0) begin
                    turn_cnt[p] <= turn_cnt[p] - 4'd1;
                end
                if (wr_err[p]) begin
                    errcnt[p] <= {7'd0, viol[p]};
                end else if (viol[p] && errcnt[p] != 8'hFF) begin
                    errcnt[p] <= errcnt[p] + 8'd1;
                end
            end
        end
    end

    assign hyper_reset_no = {NumPhys{rst_cnt == 8'd0}};

`ifdef HYPER_PAD_LOOPBACK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lb <= 1'b0;
        end else if (wr_ctrl) begin
            lb <= reg_wdata_i[1];
        end
    end

    assign dq_oe        = lb ? '0 : ctl_dq_oe_i;
    assign rwds_oe      = lb ? '0 : ctl_rwds_oe_i;
    assign ctl_dq_i_o   = lb ? ctl_dq_o_i : dq_di;
    assign ctl_rwds_i_o = lb ? ctl_rwds_o_i : rwds_di;
`else
    assign lb           = 1'b0;
    assign dq_oe        = ctl_dq_oe_i;
    assign rwds_oe      = ctl_rwds_oe_i;
    assign ctl_dq_i_o   = dq_di;
    assign ctl_rwds_i_o = rwds_di;
`endif

    // Output-only pads have OE tied high, so they reduce to straight wires.
    assign hyper_ck_o  = ctl_ck_i;
    assign hyper_ck_no = ctl_ck_n_i;
    assign hyper_cs_no = ctl_cs_n_i;

    for (genvar p = 0; p < NumPhys; p++) begin : g_phy
        for (genvar b = 0; b < DqWidth; b++) begin : g_dq
            hyperbus_pad_cell u_dq (
                .dout (ctl_dq_o_i[p*DqWidth+b]),
                .din  (dq_di[p*DqWidth+b]),
                .oe   (dq_oe[p]),
                .pad  (hyper_dq_io[p*DqWidth+b]),
                .cfg  (padcfg[p])
            );
        end
        hyperbus_pad_cell u_rwds (
            .dout (ctl_rwds_o_i[p]),
            .din  (rwds_di[p]),
            .oe   (rwds_oe[p]),
            .pad  (hyper_rwds_io[p]),
            .cfg  (padcfg[p])
        );
    end

endmodule

// File: tb/tb_hyperbus_pad_frame.sv
// Self-checking bench for hyperbus_pad_frame: timestamp/run-length reference model
// compared every cycle, plus directed literal checks.
module tb_hyperbus_pad_frame;

    localparam int NP   = 2;
    localparam int NC   = 2;
    localparam int DW   = 8;
    localparam int TURN = 2;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic              reg_req_i = 1'b0;
    logic              reg_we_i = 1'b0;
    logic [7:0]        reg_addr_i = '0;
    logic [31:0]       reg_wdata_i = '0;
    logic [31:0]       reg_rdata_o;
    logic              reg_ready_o;
    logic [NP-1:0]     ctl_ck_i = '0;
    logic [NP-1:0]     ctl_ck_n_i = '0;
    logic [NP*NC-1:0]  ctl_cs_n_i = '0;
    logic [NP*DW-1:0]  ctl_dq_o_i = '0;
    logic [NP-1:0]     ctl_dq_oe_i = '0;
    logic [NP*DW-1:0]  ctl_dq_i_o;
    logic [NP-1:0]     ctl_rwds_o_i = '0;
    logic [NP-1:0]     ctl_rwds_oe_i = '0;
    logic [NP-1:0]     ctl_rwds_i_o;
    logic [NP-1:0]     hyper_ck_o;
    logic [NP-1:0]     hyper_ck_no;
    logic [NP*NC-1:0]  hyper_cs_no;
    logic [NP-1:0]     hyper_reset_no;
    wire  [NP*DW-1:0]  hyper_dq_io;
    wire  [NP-1:0]     hyper_rwds_io;

    logic [NP*DW-1:0]  ext_dq = '0;
    logic [NP-1:0]     ext_rwds = '0;
    logic [NP-1:0]     drv_en;
    logic [NP-1:0]     rdrv_en;

    hyperbus_pad_frame #(
        .NumPhys(NP), .NumChips(NC), .DqWidth(DW),
        .TurnCycles(TURN), .RstHoldCycles(HOLD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .reg_req_i(reg_req_i), .reg_we_i(reg_we_i),
        .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
        .reg_rdata_o(reg_rdata_o), .reg_ready_o(reg_ready_o),
        .ctl_ck_i(ctl_ck_i), .ctl_ck_n_i(ctl_ck_n_i), .ctl_cs_n_i(ctl_cs_n_i),
        .ctl_dq_o_i(ctl_dq_o_i), .ctl_dq_oe_i(ctl_dq_oe_i), .ctl_dq_i_o(ctl_dq_i_o),
        .ctl_rwds_o_i(ctl_rwds_o_i), .ctl_rwds_oe_i(ctl_rwds_oe_i),
        .ctl_rwds_i_o(ctl_rwds_i_o),
        .hyper_ck_o(hyper_ck_o), .hyper_ck_no(hyper_ck_no), .hyper_cs_no(hyper_cs_no),
        .hyper_reset_no(hyper_reset_no),
        .hyper_dq_io(hyper_dq_io), .hyper_rwds_io(hyper_rwds_io)
    );

    // ---------------- reference model ----------------
    int            cyc = 0;
    int            load = 0;
    logic          m_ready = 1'b0;
    logic [31:0]   m_rdata = '0;
    logic [NP-1:0] m_status = '0;
    logic [7:0]    m_err [NP] = '{default: 8'd0};
    logic [5:0]    m_cfg [NP] = '{default: 6'd0};
    logic          m_lb = 1'b0;
    logic [NP-1:0] pv = '0;
    logic [NP-1:0] armed = '0;
    int            idle [NP] = '{default: 0};
    logic [NP-1:0] viol, clr, errwr;
    logic          acc;
    logic [31:0]   rd;

    assign drv_en  = ~(ctl_dq_oe_i & ~{NP{m_lb}});
    assign rdrv_en = ~(ctl_rwds_oe_i & ~{NP{m_lb}});

    for (genvar p = 0; p < NP; p++) begin : g_ext
        assign hyper_dq_io[p*DW +: DW] = drv_en[p] ? ext_dq[p*DW +: DW] : {DW{1'bz}};
        assign hyper_rwds_io[p] = rdrv_en[p] ? ext_rwds[p] : 1'bz;
    end

    function automatic logic [31:0] mread(input logic [7:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 8'h00) r = 32'h4842_5031;
        if (a == 8'h04) r = {30'd0, m_lb, 1'b0};
        if (a == 8'h08) r = 32'(m_status);
        for (int p = 0; p < NP; p++) begin
            if (a == 8'(16 + 4 * p)) r = 32'(m_cfg[p]);
            if (a == 8'(48 + 4 * p)) r = 32'(m_err[p]);
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_ready = 1'b0; m_rdata = '0; m_status = '0; m_lb = 1'b0;
            pv = '0; armed = '0; load = cyc;
            for (int p = 0; p < NP; p++) begin
                m_err[p] = '0; m_cfg[p] = '0; idle[p] = 0;
            end
        end else begin
            cyc++;
            acc = reg_req_i && !m_ready;
            viol = '0; clr = '0; errwr = '0;
            // a rise after fewer than TURN idle cycles since a real fall
            for (int p = 0; p < NP; p++) begin
                if (!ctl_dq_oe_i[p]) begin
                    if (pv[p]) begin idle[p] = 1; armed[p] = 1'b1; end
                    else idle[p] = idle[p] + 1;
                end else if (!pv[p]) begin
                    if (armed[p] && idle[p] < TURN) viol[p] = 1'b1;
                    armed[p] = 1'b0;
                end
                pv[p] = ctl_dq_oe_i[p];
            end
            rd = (acc && !reg_we_i) ? mread(reg_addr_i) : '0;
            if (acc && reg_we_i) begin
                if (reg_addr_i == 8'h04) begin
                    if (reg_wdata_i[0]) load = cyc;
`ifdef HYPER_PAD_LOOPBACK_EN
                    m_lb = reg_wdata_i[1];
`endif
                end
                if (reg_addr_i == 8'h08) clr = reg_wdata_i[NP-1:0];
                for (int p = 0; p < NP; p++) begin
                    if (reg_addr_i == 8'(16 + 4 * p)) m_cfg[p] = reg_wdata_i[5:0];
                    if (reg_addr_i == 8'(48 + 4 * p)) errwr[p] = 1'b1;
                end
            end
            m_status = (m_status & ~clr) | viol;
            for (int p = 0; p < NP; p++) begin
                if (errwr[p]) m_err[p] = viol[p] ? 8'd1 : 8'd0;
                else if (viol[p] && m_err[p] != 8'd255) m_err[p] = m_err[p] + 8'd1;
            end
            m_ready = acc;
            m_rdata = rd;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] ep;
        logic          er;
        chk("ready", 64'(reg_ready_o), 64'(m_ready));
        if (m_ready) chk("rdata", 64'(reg_rdata_o), 64'(m_rdata));
        chk("reset_n", 64'(hyper_reset_no), ((cyc - load) >= HOLD) ? 64'(2'b11) : 64'd0);
        chk("ck", 64'({hyper_ck_o, hyper_ck_no}), 64'({ctl_ck_i, ctl_ck_n_i}));
        chk("cs_n", 64'(hyper_cs_no), 64'(ctl_cs_n_i));
        for (int p = 0; p < NP; p++) begin
            ep = (ctl_dq_oe_i[p] && !m_lb) ? ctl_dq_o_i[p*DW +: DW] : ext_dq[p*DW +: DW];
            er = (ctl_rwds_oe_i[p] && !m_lb) ? ctl_rwds_o_i[p] : ext_rwds[p];
            chk("dq_pad", 64'(hyper_dq_io[p*DW +: DW]), 64'(ep));
            chk("dq_in", 64'(ctl_dq_i_o[p*DW +: DW]),
                64'(m_lb ? ctl_dq_o_i[p*DW +: DW] : ep));
            chk("rwds_pad", 64'(hyper_rwds_io[p]), 64'(er));
            chk("rwds_in", 64'(ctl_rwds_i_o[p]), 64'(m_lb ? ctl_rwds_o_i[p] : er));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic reg_acc(input logic we, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] r);
        bit got;
        got = 1'b0;
        @(posedge clk); #2;
        reg_req_i = 1'b1; reg_we_i = we; reg_addr_i = a; reg_wdata_i = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (reg_ready_o) got = 1'b1;
        end
        if (!got) chk("ready_timeout", 64'd0, 64'd1);
        r = reg_rdata_o;
        @(posedge clk); #2;
        reg_req_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] addrs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
                               8'h14, 8'h30, 8'h34, 8'h38, 8'h50};

    initial begin
        logic [31:0] r;
        int n;
        repeat (3) @(posedge clk);
        #2 rst_ni = 1'b1;

        n = 0;
        while (n < 100) begin
            @(posedge clk); n++; #1;
            if (hyper_reset_no === 2'b11) break;
        end
        chk("reset_hold_cycles", 64'(n), 64'd16);

        reg_acc(1'b0, 8'h00, 0, r); chk("id", 64'(r), 64'h4842_5031);
        reg_acc(1'b1, 8'h14, 32'h35, r);
        reg_acc(1'b0, 8'h14, 0, r); chk("padcfg1_rb", 64'(r), 64'h35);
        reg_acc(1'b0, 8'h10, 0, r); chk("padcfg0_rb", 64'(r), 64'h0);
        chk("padcfg1_pins", 64'(dut.padcfg[1]), 64'h35);
        chk("padcfg0_pins", 64'(dut.padcfg[0]), 64'h0);
        reg_acc(1'b0, 8'h0C, 0, r); chk("unmapped", 64'(r), 64'h0);

        // PHY0: one idle cycle -> violation
        ctl_dq_oe_i[0] = 1'b1; tick(2);
        ctl_dq_oe_i[0] = 1'b0; tick(1);
        ctl_dq_oe_i[0] = 1'b1; tick(2);
        reg_acc(1'b0, 8'h08, 0, r); chk("status_viol", 64'(r), 64'h1);
        reg_acc(1'b0, 8'h30, 0, r); chk("errcnt0_one", 64'(r), 64'h1);
        reg_acc(1'b1, 8'h08, 32'h1, r);
        // PHY0: two idle cycles -> legal
        ctl_dq_oe_i[0] = 1'b0; tick(2);
        ctl_dq_oe_i[0] = 1'b1; tick(2);
        reg_acc(1'b0, 8'h30, 0, r); chk("errcnt0_legal", 64'(r), 64'h1);
        reg_acc(1'b0, 8'h08, 0, r); chk("status_clear", 64'(r), 64'h0);

        for (int i = 0; i < 300; i++) begin
            ctl_dq_oe_i[1] = 1'b1; tick(1);
            ctl_dq_oe_i[1] = 1'b0; tick(1);
        end
        ctl_dq_oe_i[1] = 1'b1; tick(2);
        reg_acc(1'b0, 8'h34, 0, r); chk("errcnt1_sat", 64'(r), 64'd255);
        reg_acc(1'b1, 8'h34, 32'h1234, r);
        reg_acc(1'b0, 8'h34, 0, r); chk("errcnt1_clr", 64'(r), 64'd0);
        reg_acc(1'b0, 8'h08, 0, r); chk("status_phy1", 64'(r), 64'h2);
        reg_acc(1'b1, 8'h08, 32'h2, r);
        reg_acc(1'b0, 8'h08, 0, r); chk("status_w1c", 64'(r), 64'h0);

        // SW reset, then a second one while the count is still running
        reg_acc(1'b1, 8'h04, 32'h1, r);
        tick(5);
        @(posedge clk); #2;
        reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = 8'h04; reg_wdata_i = 32'h1;
        @(posedge clk);
        n = 0;
        while (n < 100) begin
            #1;
            if (n == 1) reg_req_i = 1'b0;
            if (hyper_reset_no === 2'b11) break;
            @(posedge clk); n++;
        end
        reg_req_i = 1'b0;
        chk("swrst_hold_cycles", 64'(n), 64'd16);
        reg_acc(1'b0, 8'h04, 0, r); chk("ctrl_read", 64'(r), 64'h0);

`ifdef HYPER_PAD_LOOPBACK_EN
        reg_acc(1'b1, 8'h04, 32'h2, r);
        ctl_dq_o_i[DW-1:0] = 8'hA5; ext_dq[DW-1:0] = 8'h5A;
        ctl_dq_oe_i[0] = 1'b1; tick(1);
        @(negedge clk);
        chk("lb_dq_in", 64'(ctl_dq_i_o[DW-1:0]), 64'hA5);
        chk("lb_pad_oe_off", 64'(hyper_dq_io[DW-1:0]), 64'h5A);
        reg_acc(1'b1, 8'h04, 32'h0, r);
`endif

        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    for (int p = 0; p < NP; p++) begin
                        if ($urandom_range(2) == 0) ctl_dq_oe_i[p] = ~ctl_dq_oe_i[p];
                    end
                    ctl_dq_o_i    = NP*DW'($urandom);
                    ext_dq        = NP*DW'($urandom);
                    ctl_rwds_o_i  = NP'($urandom);
                    ctl_rwds_oe_i = NP'($urandom);
                    ext_rwds      = NP'($urandom);
                    ctl_ck_i      = NP'($urandom);
                    ctl_ck_n_i    = NP'($urandom);
                    ctl_cs_n_i    = (NP*NC)'($urandom);
                    tick(1);
                end
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    reg_acc(1'($urandom), addrs[$urandom_range(9)], $urandom, r);
                    tick($urandom_range(3));
                end
            end
        join

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
